// File: rtl/nox_utils_pkg.sv
// nox_utils_pkg
// Shared types for the AXI memory arbiter: arbiter FSM state enums, the
// master/slave AXI4 bundle structs and bus width constants.
// Ports: none (package).
package nox_utils_pkg;

  localparam int NUM_ARB_MASTERS = 2;
  localparam int AXI_ADDR_W      = 32;
  localparam int AXI_DATA_W      = 32;
  localparam int AXI_ID_W        = 4;

  localparam logic [1:0] AXI_RESP_OKAY = 2'b00;

  typedef enum logic [1:0] {
    RD_IDLE,
    RD_ADDR,
    RD_DATA
  } arb_rd_st_t;

  typedef enum logic [1:0] {
    WR_IDLE,
    WR_ADDR,
    WR_DATA,
    WR_RESP
  } arb_wr_st_t;

  // Master-to-slave direction of one AXI4 port.
  typedef struct packed {
    logic [AXI_ID_W-1:0]     awid;
    logic [AXI_ADDR_W-1:0]   awaddr;
    logic [7:0]              awlen;
    logic [2:0]              awsize;
    logic [1:0]              awburst;
    logic                    awvalid;
    logic [AXI_DATA_W-1:0]   wdata;
    logic [AXI_DATA_W/8-1:0] wstrb;
    logic                    wlast;
    logic                    wvalid;
    logic                    bready;
    logic [AXI_ID_W-1:0]     arid;
    logic [AXI_ADDR_W-1:0]   araddr;
    logic [7:0]              arlen;
    logic [2:0]              arsize;
    logic [1:0]              arburst;
    logic                    arvalid;
    logic                    rready;
  } s_axi_mosi_t;

  // Slave-to-master direction of one AXI4 port.
  typedef struct packed {
    logic                  awready;
    logic                  wready;
    logic [AXI_ID_W-1:0]   bid;
    logic [1:0]            bresp;
    logic                  bvalid;
    logic                  arready;
    logic [AXI_ID_W-1:0]   rid;
    logic [AXI_DATA_W-1:0] rdata;
    logic [1:0]            rresp;
    logic                  rlast;
    logic                  rvalid;
  } s_axi_miso_t;

endpackage

// File: rtl/axi_arb_rr_pick.sv
// axi_arb_rr_pick
// Two-requester picker with a registered priority pointer. The grant is
// combinational from req and the pointer. With NOX_ARB_RR_EN defined the
// pointer moves to the master that was not served whenever update pulses;
// otherwise the pointer stays at INIT_PRIO forever (fixed priority).
// Ports:
//   clk, rst  clock and asynchronous active-low reset
//   req       request vector, bit i = master i
//   update    one-cycle strobe: the served transaction completed
//   served    index of the master whose transaction completed
//   gnt       one-hot grant, 0 when no request
module axi_arb_rr_pick
  import nox_utils_pkg::*;
#(
  parameter int INIT_PRIO = 0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_ARB_MASTERS-1:0] req,
  input  logic                       update,
  input  logic                       served,
  output logic [NUM_ARB_MASTERS-1:0] gnt
);

  logic prio;

`ifdef NOX_ARB_RR_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)        prio <= INIT_PRIO[0];
    else if (update) prio <= ~served;
  end
`else
  logic unused_update;
  assign unused_update = update ^ served;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) prio <= INIT_PRIO[0];
    else      prio <= prio;
  end
`endif

  always_comb begin
    gnt = '0;
    if (req[prio])       gnt[prio]  = 1'b1;
    else if (req[~prio]) gnt[~prio] = 1'b1;
  end

endmodule

// File: rtl/axi_mem_arbiter.sv
// axi_mem_arbiter
// Shares one AXI4 slave (the on-chip RAM wrapper) between the fetch port
// (master 0) and the load/store port (master 1). Read and write channels are
// arbitrated independently, one transaction in flight per channel, grant held
// until the burst terminates on rlast / wlast+B. Adds one cycle of
// address-phase latency. Build macro NOX_ARB_RR_EN selects round-robin
// arbitration; default is fixed priority at INIT_PRIO.
// Ports:
//   clk, rst                 clock, asynchronous active-low reset
//   m0_axi_mosi/m0_axi_miso  master 0 (fetch) request/response
//   m1_axi_mosi/m1_axi_miso  master 1 (LSU) request/response
//   s_axi_mosi/s_axi_miso    towards/from the memory wrapper
//   rd_gnt, wr_gnt           one-hot channel grants, 0 while idle
//
// Read FSM
//   state    | meaning
//   RD_IDLE  | no read owner; arbitrate on arvalid
//   RD_ADDR  | granted master's AR forwarded to slave
//   RD_DATA  | slave R routed to granted master until rlast
// Write FSM
//   state    | meaning
//   WR_IDLE  | no write owner; arbitrate on awvalid
//   WR_ADDR  | granted master's AW forwarded, W held off
//   WR_DATA  | W forwarded until wlast
//   WR_RESP  | slave B routed to granted master
module axi_mem_arbiter
  import nox_utils_pkg::*;
#(
  parameter int INIT_PRIO = 0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  s_axi_mosi_t                m0_axi_mosi,
  output s_axi_miso_t                m0_axi_miso,
  input  s_axi_mosi_t                m1_axi_mosi,
  output s_axi_miso_t                m1_axi_miso,
  output s_axi_mosi_t                s_axi_mosi,
  input  s_axi_miso_t                s_axi_miso,
  output logic [NUM_ARB_MASTERS-1:0] rd_gnt,
  output logic [NUM_ARB_MASTERS-1:0] wr_gnt
);

  arb_rd_st_t rd_st, rd_st_d;
  arb_wr_st_t wr_st, wr_st_d;

  logic [NUM_ARB_MASTERS-1:0] rd_gnt_d, wr_gnt_d;
  logic [NUM_ARB_MASTERS-1:0] ar_req, aw_req;
  logic [NUM_ARB_MASTERS-1:0] rd_pick, wr_pick;
  logic                       rd_idx, wr_idx;
  logic                       rd_done, wr_done;
  s_axi_mosi_t                rd_src, wr_src;
  s_axi_miso_t                m_miso [NUM_ARB_MASTERS];

  assign ar_req = {m1_axi_mosi.arvalid, m0_axi_mosi.arvalid};
  assign aw_req = {m1_axi_mosi.awvalid, m0_axi_mosi.awvalid};

  // Routing follows the registered grant, never the transaction ID.
  assign rd_idx = rd_gnt[1];
  assign wr_idx = wr_gnt[1];
  assign rd_src = rd_idx ? m1_axi_mosi : m0_axi_mosi;
  assign wr_src = wr_idx ? m1_axi_mosi : m0_axi_mosi;

  assign rd_done = (rd_st == RD_DATA) && s_axi_miso.rvalid && rd_src.rready
                   && s_axi_miso.rlast;
  assign wr_done = (wr_st == WR_RESP) && s_axi_miso.bvalid && wr_src.bready;

  axi_arb_rr_pick #(.INIT_PRIO(INIT_PRIO)) u_rd_pick (
    .clk    (clk),
    .rst    (rst),
    .req    (ar_req),
    .update (rd_done),
    .served (rd_idx),
    .gnt    (rd_pick)
  );

  axi_arb_rr_pick #(.INIT_PRIO(INIT_PRIO)) u_wr_pick (
    .clk    (clk),
    .rst    (rst),
    .req    (aw_req),
    .update (wr_done),
    .served (wr_idx),
    .gnt    (wr_pick)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_st  <= RD_IDLE;
      wr_st  <= WR_IDLE;
      rd_gnt <= '0;
      wr_gnt <= '0;
    end else begin
      rd_st  <= rd_st_d;
      wr_st  <= wr_st_d;
      rd_gnt <= rd_gnt_d;
      wr_gnt <= wr_gnt_d;
    end
  end

  always_comb begin
    rd_st_d  = rd_st;
    rd_gnt_d = rd_gnt;
    case (rd_st)
      RD_IDLE: if (|ar_req) begin
        rd_st_d  = RD_ADDR;
        rd_gnt_d = rd_pick;
      end
      RD_ADDR: if (rd_src.arvalid && s_axi_miso.arready) rd_st_d = RD_DATA;
      RD_DATA: if (rd_done) begin
        rd_st_d  = RD_IDLE;
        rd_gnt_d = '0;
      end
      default: begin
        rd_st_d  = RD_IDLE;
        rd_gnt_d = '0;
      end
    endcase
  end

  always_comb begin
    wr_st_d  = wr_st;
    wr_gnt_d = wr_gnt;
    case (wr_st)
      WR_IDLE: if (|aw_req) begin
        wr_st_d  = WR_ADDR;
        wr_gnt_d = wr_pick;
      end
      WR_ADDR: if (wr_src.awvalid && s_axi_miso.awready) wr_st_d = WR_DATA;
      WR_DATA: if (wr_src.wvalid && s_axi_miso.wready && wr_src.wlast)
        wr_st_d = WR_RESP;
      WR_RESP: if (wr_done) begin
        wr_st_d  = WR_IDLE;
        wr_gnt_d = '0;
      end
      default: begin
        wr_st_d  = WR_IDLE;
        wr_gnt_d = '0;
      end
    endcase
  end

  // Everything not owned by the current state stays at zero, so the
  // non-granted master only ever sees idle readies/valids.
  always_comb begin
    s_axi_mosi = '0;
    m_miso[0]  = '0;
    m_miso[1]  = '0;

    if (rd_st == RD_ADDR) begin
      s_axi_mosi.arid        = rd_src.arid;
      s_axi_mosi.araddr      = rd_src.araddr;
      s_axi_mosi.arlen       = rd_src.arlen;
      s_axi_mosi.arsize      = rd_src.arsize;
      s_axi_mosi.arburst     = rd_src.arburst;
      s_axi_mosi.arvalid     = rd_src.arvalid;
      m_miso[rd_idx].arready = s_axi_miso.arready;
    end

    if (rd_st == RD_DATA) begin
      s_axi_mosi.rready     = rd_src.rready;
      m_miso[rd_idx].rid    = s_axi_miso.rid;
      m_miso[rd_idx].rdata  = s_axi_miso.rdata;
      m_miso[rd_idx].rresp  = s_axi_miso.rresp;
      m_miso[rd_idx].rlast  = s_axi_miso.rlast;
      m_miso[rd_idx].rvalid = s_axi_miso.rvalid;
    end

    if (wr_st == WR_ADDR) begin
      s_axi_mosi.awid        = wr_src.awid;
      s_axi_mosi.awaddr      = wr_src.awaddr;
      s_axi_mosi.awlen       = wr_src.awlen;
      s_axi_mosi.awsize      = wr_src.awsize;
      s_axi_mosi.awburst     = wr_src.awburst;
      s_axi_mosi.awvalid     = wr_src.awvalid;
      m_miso[wr_idx].awready = s_axi_miso.awready;
    end

    // W issued before the AW handshake simply waits here with wready low.
    if (wr_st == WR_DATA) begin
      s_axi_mosi.wdata      = wr_src.wdata;
      s_axi_mosi.wstrb      = wr_src.wstrb;
      s_axi_mosi.wlast      = wr_src.wlast;
      s_axi_mosi.wvalid     = wr_src.wvalid;
      m_miso[wr_idx].wready = s_axi_miso.wready;
    end

    if (wr_st == WR_RESP) begin
      s_axi_mosi.bready     = wr_src.bready;
      m_miso[wr_idx].bid    = s_axi_miso.bid;
      m_miso[wr_idx].bresp  = s_axi_miso.bresp;
      m_miso[wr_idx].bvalid = s_axi_miso.bvalid;
    end
  end

  assign m0_axi_miso = m_miso[0];
  assign m1_axi_miso = m_miso[1];

endmodule
